// File: rtl/gray_codec_pkg.sv
// Shared types and reference conversions for the pipelined Binary/Gray codec.
// Covers both the default build and the GRAY_CODEC_PARITY_EN build.
package gray_codec_pkg;

    typedef enum logic {
        MODE_B2G = 1'b0,
        MODE_G2B = 1'b1
    } mode_e;

    // Widest word the reference functions handle; zero-extended inputs convert correctly.
    localparam int GC_MAX_W = 64;

    function automatic int bits_per_stage(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    function automatic logic [GC_MAX_W-1:0] bin2gray(input logic [GC_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GC_MAX_W-1:0] gray2bin(input logic [GC_MAX_W-1:0] g);
        logic [GC_MAX_W-1:0] b;
        b[GC_MAX_W-1] = g[GC_MAX_W-1];
        for (int i = GC_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_codec_stage.sv
// One codec pipeline stage: resolves decode bits [HI:LO] (first stage also encodes).
// GRAY_CODEC_PARITY_EN adds a registered parity output, driven only in the last stage.
module gray_codec_stage
    import gray_codec_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int HI    = 7,
    parameter int LO    = 0,
    parameter bit FIRST = 1'b0,
    parameter bit LAST  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  mode_e            in_mode,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output mode_e            out_mode
`ifdef GRAY_CODEC_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    logic [WIDTH-1:0]    nxt;
    logic [GC_MAX_W-1:0] wide;

    // Bits above this stage's slice are already binary, so resolving in place MSB-first is exact.
    always_comb begin
        nxt  = in_data;
        wide = '0;
        if (in_mode == MODE_G2B) begin
            for (int i = WIDTH - 2; i >= 0; i--) begin
                if (i >= LO && i <= HI) begin
                    nxt[i] = nxt[i+1] ^ nxt[i];
                end
            end
        end else if (FIRST) begin
            wide[WIDTH-1:0] = in_data;
            wide            = bin2gray(wide);
            nxt             = wide[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mode  <= MODE_B2G;
        end else if (en) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= nxt;
                out_mode <= in_mode;
            end
        end
    end

`ifdef GRAY_CODEC_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_parity <= 1'b0;
        end else if (en && in_valid) begin
            out_parity <= LAST ? ^nxt : 1'b0;
        end
    end
`endif

endmodule

// File: rtl/gray_codec_pipe.sv
// Pipelined Binary/Gray codec with valid/ready handshake; latency equals STAGES.
// Optional out_parity port under GRAY_CODEC_PARITY_EN.
module gray_codec_pipe
    import gray_codec_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode
`ifdef GRAY_CODEC_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    localparam int BPS = bits_per_stage(WIDTH, STAGES);

    logic             en;
    logic [STAGES:0]  v;
    logic [WIDTH-1:0] d [STAGES+1];
    mode_e            m [STAGES+1];
`ifdef GRAY_CODEC_PARITY_EN
    logic [STAGES-1:0] par;
`endif

    // Whole pipe moves in lockstep; bubbles shift too so gaps are preserved.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    assign v[0] = in_valid;
    assign d[0] = in_data;
    assign m[0] = mode_e'(in_mode);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int HI = WIDTH - 1 - k * BPS;
        localparam int LO = (HI - BPS + 1 < 0) ? 0 : HI - BPS + 1;

        gray_codec_stage #(
            .WIDTH (WIDTH),
            .HI    (HI),
            .LO    (LO),
            .FIRST (k == 0),
            .LAST  (k == STAGES - 1)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .in_valid  (v[k]),
            .in_data   (d[k]),
            .in_mode   (m[k]),
            .out_valid (v[k+1]),
            .out_data  (d[k+1]),
            .out_mode  (m[k+1])
`ifdef GRAY_CODEC_PARITY_EN
            ,
            .out_parity(par[k])
`endif
        );
    end

    assign out_valid = v[STAGES];
    assign out_data  = d[STAGES];
    assign out_mode  = logic'(m[STAGES]);
`ifdef GRAY_CODEC_PARITY_EN
    assign out_parity = par[STAGES-1];
`endif

endmodule
